// File: rtl/mcctrl_rv32i_pkg.sv
// mcctrl_pkg: shared types and codes for the multicycle RV32I control unit.
// Holds the FSM state enum, opcode values, ALUControl codes and the
// datapath mux select encodings.
package mcctrl_pkg;

    typedef enum logic [3:0] {
        S_FETCH,
        S_DECODE,
        S_MEMADR,
        S_MEMREAD,
        S_MEMWB,
        S_MEMWRITE,
        S_EXECR,
        S_EXECI,
        S_ALUWB,
        S_JAL,
        S_JALR,
        S_JALRWB,
        S_LUI,
        S_AUIPC,
        S_BRANCH,
        S_TRAP
    } state_t;

    // What the ALU decoder should produce: forced add, forced sub, or funct decode
    typedef enum logic [1:0] {
        ALU_MODE_ADD,
        ALU_MODE_SUB,
        ALU_MODE_DEC
    } alumode_t;

    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_RTYPE  = 7'b0110011;
    localparam logic [6:0] OP_ITYPE  = 7'b0010011;
    localparam logic [6:0] OP_JAL    = 7'b1101111;
    localparam logic [6:0] OP_JALR   = 7'b1100111;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_LUI    = 7'b0110111;
    localparam logic [6:0] OP_AUIPC  = 7'b0010111;

    localparam logic [3:0] ALU_ADD  = 4'd0;
    localparam logic [3:0] ALU_SUB  = 4'd1;
    localparam logic [3:0] ALU_AND  = 4'd2;
    localparam logic [3:0] ALU_OR   = 4'd3;
    localparam logic [3:0] ALU_XOR  = 4'd4;
    localparam logic [3:0] ALU_SLT  = 4'd5;
    localparam logic [3:0] ALU_SLTU = 4'd6;
    localparam logic [3:0] ALU_SLL  = 4'd7;
    localparam logic [3:0] ALU_SRL  = 4'd8;
    localparam logic [3:0] ALU_SRA  = 4'd9;

    localparam logic [2:0] IMM_I = 3'b000;
    localparam logic [2:0] IMM_S = 3'b001;
    localparam logic [2:0] IMM_B = 3'b010;
    localparam logic [2:0] IMM_J = 3'b011;
    localparam logic [2:0] IMM_U = 3'b100;

    localparam logic [1:0] SRCA_PC    = 2'b00;
    localparam logic [1:0] SRCA_OLDPC = 2'b01;
    localparam logic [1:0] SRCA_RS1   = 2'b10;
    localparam logic [1:0] SRCA_ZERO  = 2'b11;

    localparam logic [1:0] SRCB_RS2  = 2'b00;
    localparam logic [1:0] SRCB_IMM  = 2'b01;
    localparam logic [1:0] SRCB_FOUR = 2'b10;

    localparam logic [1:0] RES_ALUOUT = 2'b00;
    localparam logic [1:0] RES_DATA   = 2'b01;
    localparam logic [1:0] RES_ALURES = 2'b10;

endpackage

// File: rtl/mcctrl_rv32i_if.sv
// mcctrl_rv32i_if: control bus between the controller (master) and the
// multicycle datapath (slave): instruction fields and ALU flags in,
// mux selects and write enables out.
interface mcctrl_rv32i_if #(parameter int ALUCTRL_W = 4);
    logic [6:0]           op;
    logic [2:0]           funct3;
    logic                 funct7b5;
    logic                 Zero;
    logic                 Neg;
    logic                 Ovf;
    logic                 Carry;
    logic                 MemReady;
    logic [2:0]           ImmSrc;
    logic [1:0]           ALUSrcA;
    logic [1:0]           ALUSrcB;
    logic [1:0]           ResultSrc;
    logic                 AdrSrc;
    logic [ALUCTRL_W-1:0] ALUControl;
    logic                 IRWrite;
    logic                 PCWrite;
    logic                 RegWrite;
    logic                 MemWrite;
    logic                 Fault;

    modport master (
        input  op, funct3, funct7b5, Zero, Neg, Ovf, Carry, MemReady,
        output ImmSrc, ALUSrcA, ALUSrcB, ResultSrc, AdrSrc, ALUControl,
               IRWrite, PCWrite, RegWrite, MemWrite, Fault
    );

    modport slave (
        output op, funct3, funct7b5, Zero, Neg, Ovf, Carry, MemReady,
        input  ImmSrc, ALUSrcA, ALUSrcB, ResultSrc, AdrSrc, ALUControl,
               IRWrite, PCWrite, RegWrite, MemWrite, Fault
    );
endinterface

// File: rtl/mcctrl_rv32i_aludec.sv
// mcctrl_aludec: combinational ALU operation decoder. Produces a forced
// add/sub or decodes funct3/funct7b5; 4-bit codes are zero-extended.
import mcctrl_pkg::*;

module mcctrl_aludec #(
    parameter int ALUCTRL_W = 4
) (
    input  logic                 op5,
    input  logic [2:0]           funct3,
    input  logic                 funct7b5,
    input  alumode_t             mode,
    output logic [ALUCTRL_W-1:0] alucontrol
);

    logic [3:0] code;

    // Pick the operation; sub on funct3=000 only for R-type (op5 set)
    always_comb begin
        code = ALU_ADD;
        case (mode)
            ALU_MODE_ADD: code = ALU_ADD;
            ALU_MODE_SUB: code = ALU_SUB;
            default: begin
                case (funct3)
                    3'b000:  code = (op5 & funct7b5) ? ALU_SUB : ALU_ADD;
                    3'b001:  code = ALU_SLL;
                    3'b010:  code = ALU_SLT;
                    3'b011:  code = ALU_SLTU;
                    3'b100:  code = ALU_XOR;
                    3'b101:  code = funct7b5 ? ALU_SRA : ALU_SRL;
                    3'b110:  code = ALU_OR;
                    default: code = ALU_AND;
                endcase
            end
        endcase
    end

    assign alucontrol = ALUCTRL_W'(code);

endmodule

// File: rtl/mcctrl_rv32i.sv
// mcctrl_rv32i: multicycle RV32I control FSM. Moore outputs from the state
// register, except PCWrite in BRANCH (flag dependent) and memory-ready gating.
// Optional macro MCCTRL_MEMWAIT_EN: FETCH/MEMREAD/MEMWRITE wait for MemReady.
import mcctrl_pkg::*;

module mcctrl_rv32i #(
    parameter int ALUCTRL_W = 4
) (
    input  logic           clk,
    input  logic           reset,
    mcctrl_rv32i_if.master bus
);

    state_t   state, state_nxt;
    alumode_t alu_mode;
    logic     mem_ok;
    logic     taken;

`ifdef MCCTRL_MEMWAIT_EN
    assign mem_ok = bus.MemReady;
`else
    logic unused_memready;
    assign unused_memready = bus.MemReady;
    assign mem_ok = 1'b1;
`endif

    // Branch condition from the flags of rs1 - rs2
    always_comb begin
        case (bus.funct3)
            3'b000:  taken = bus.Zero;
            3'b001:  taken = ~bus.Zero;
            3'b100:  taken = bus.Neg ^ bus.Ovf;
            3'b101:  taken = ~(bus.Neg ^ bus.Ovf);
            3'b110:  taken = ~bus.Carry;
            3'b111:  taken = bus.Carry;
            default: taken = 1'b0;
        endcase
    end

    // State register; reset forces FETCH asynchronously
    always_ff @(posedge clk or posedge reset) begin
        if (reset) state <= S_FETCH;
        else       state <= state_nxt;
    end

    // Next state and per-state datapath controls
    always_comb begin
        state_nxt     = state;
        alu_mode      = ALU_MODE_ADD;
        bus.ImmSrc    = IMM_I;
        bus.ALUSrcA   = SRCA_PC;
        bus.ALUSrcB   = SRCB_RS2;
        bus.ResultSrc = RES_ALUOUT;
        bus.AdrSrc    = 1'b0;
        bus.IRWrite   = 1'b0;
        bus.PCWrite   = 1'b0;
        bus.RegWrite  = 1'b0;
        bus.MemWrite  = 1'b0;
        bus.Fault     = 1'b0;
        case (state)
            S_FETCH: begin
                bus.IRWrite   = mem_ok;
                bus.ALUSrcB   = SRCB_FOUR;
                bus.ResultSrc = RES_ALURES;
                bus.PCWrite   = mem_ok;
                if (mem_ok) state_nxt = S_DECODE;
            end
            S_DECODE: begin
                bus.ALUSrcA = SRCA_OLDPC;
                bus.ALUSrcB = SRCB_IMM;
                bus.ImmSrc  = (bus.op == OP_BRANCH) ? IMM_B : IMM_J;
                case (bus.op)
                    OP_LOAD, OP_STORE: state_nxt = S_MEMADR;
                    OP_RTYPE:          state_nxt = S_EXECR;
                    OP_ITYPE:          state_nxt = S_EXECI;
                    OP_JAL:            state_nxt = S_JAL;
                    OP_JALR:           state_nxt = S_JALR;
                    OP_BRANCH:         state_nxt = (bus.funct3[2:1] == 2'b01) ? S_TRAP : S_BRANCH;
                    OP_LUI:            state_nxt = S_LUI;
                    OP_AUIPC:          state_nxt = S_AUIPC;
                    default:           state_nxt = S_TRAP;
                endcase
            end
            S_MEMADR: begin
                bus.ALUSrcA = SRCA_RS1;
                bus.ALUSrcB = SRCB_IMM;
                bus.ImmSrc  = (bus.op == OP_STORE) ? IMM_S : IMM_I;
                state_nxt   = (bus.op == OP_STORE) ? S_MEMWRITE : S_MEMREAD;
            end
            S_MEMREAD: begin
                bus.AdrSrc = 1'b1;
                if (mem_ok) state_nxt = S_MEMWB;
            end
            S_MEMWB: begin
                bus.ResultSrc = RES_DATA;
                bus.RegWrite  = 1'b1;
                state_nxt     = S_FETCH;
            end
            S_MEMWRITE: begin
                bus.AdrSrc   = 1'b1;
                bus.MemWrite = 1'b1;
                if (mem_ok) state_nxt = S_FETCH;
            end
            S_EXECR: begin
                bus.ALUSrcA = SRCA_RS1;
                alu_mode    = ALU_MODE_DEC;
                state_nxt   = S_ALUWB;
            end
            S_EXECI: begin
                bus.ALUSrcA = SRCA_RS1;
                bus.ALUSrcB = SRCB_IMM;
                alu_mode    = ALU_MODE_DEC;
                state_nxt   = S_ALUWB;
            end
            S_ALUWB: begin
                bus.RegWrite = 1'b1;
                state_nxt    = S_FETCH;
            end
            S_JAL: begin
                bus.ALUSrcA = SRCA_OLDPC;
                bus.ALUSrcB = SRCB_FOUR;
                bus.PCWrite = 1'b1;
                state_nxt   = S_ALUWB;
            end
            S_JALR: begin
                bus.ALUSrcA   = SRCA_RS1;
                bus.ALUSrcB   = SRCB_IMM;
                bus.ResultSrc = RES_ALURES;
                bus.PCWrite   = 1'b1;
                state_nxt     = S_JALRWB;
            end
            S_JALRWB: begin
                bus.ALUSrcA   = SRCA_OLDPC;
                bus.ALUSrcB   = SRCB_FOUR;
                bus.ResultSrc = RES_ALURES;
                bus.RegWrite  = 1'b1;
                state_nxt     = S_FETCH;
            end
            S_LUI: begin
                bus.ALUSrcA = SRCA_ZERO;
                bus.ALUSrcB = SRCB_IMM;
                bus.ImmSrc  = IMM_U;
                state_nxt   = S_ALUWB;
            end
            S_AUIPC: begin
                bus.ALUSrcA = SRCA_OLDPC;
                bus.ALUSrcB = SRCB_IMM;
                bus.ImmSrc  = IMM_U;
                state_nxt   = S_ALUWB;
            end
            S_BRANCH: begin
                bus.ALUSrcA = SRCA_RS1;
                alu_mode    = ALU_MODE_SUB;
                bus.PCWrite = taken;
                state_nxt   = S_FETCH;
            end
            default: begin
                bus.Fault = 1'b1;
                state_nxt = S_TRAP;
            end
        endcase
        // While reset is held the fetch enables read high regardless of memory
        if (reset) begin
            bus.IRWrite = 1'b1;
            bus.PCWrite = 1'b1;
        end
    end

    mcctrl_aludec #(.ALUCTRL_W(ALUCTRL_W)) u_aludec (
        .op5        (bus.op[5]),
        .funct3     (bus.funct3),
        .funct7b5   (bus.funct7b5),
        .mode       (alu_mode),
        .alucontrol (bus.ALUControl)
    );

endmodule

// File: tb/tb_mcctrl_rv32i.sv
// tb_mcctrl_rv32i: directed checks of the mcctrl_rv32i state sequence and
// per-state outputs with hand-computed expected output vectors.
module tb_mcctrl_rv32i;

    typedef logic [18:0] vec_t;

    logic clk;
    logic reset;
    int   nchk;
    int   nerr;

    mcctrl_rv32i_if #(.ALUCTRL_W(4)) bus ();

    mcctrl_rv32i #(.ALUCTRL_W(4)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Packed view of every controller output
    function automatic vec_t outs();
        return {bus.ImmSrc, bus.ALUSrcA, bus.ALUSrcB, bus.ResultSrc, bus.AdrSrc,
                bus.ALUControl, bus.IRWrite, bus.PCWrite, bus.RegWrite,
                bus.MemWrite, bus.Fault};
    endfunction

    function automatic vec_t mk(logic [2:0] imm, logic [1:0] a, logic [1:0] b,
                                logic [1:0] r, logic adr, logic [3:0] alu,
                                logic ir, logic pc, logic rw, logic mw, logic f);
        return {imm, a, b, r, adr, alu, ir, pc, rw, mw, f};
    endfunction

    vec_t V_FETCH, V_DEC_J, V_DEC_B, V_ALUWB, V_TRAP;

    task automatic set_in(logic [6:0] op, logic [2:0] f3, logic f7);
        bus.op       = op;
        bus.funct3   = f3;
        bus.funct7b5 = f7;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        set_in(7'd0, 3'd0, 1'b0);
        {bus.Zero, bus.Neg, bus.Ovf, bus.Carry} = 4'b0;
        bus.MemReady = 1'b1;
        #12;
        nchk++;
        if (outs() !== V_FETCH) begin
            nerr++;
            $display("FAIL reset_outputs: got %h expected %h", outs(), V_FETCH);
        end
        @(negedge clk);
        reset = 1'b0;
    endtask

    task automatic test_rtype();
        vec_t e[$];
        set_in(7'b0110011, 3'b101, 1'b1);
        e = {V_FETCH, V_DEC_J, mk(3'd0, 2'd2, 2'd0, 2'd0, 1'b0, 4'd9, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0),
             V_ALUWB, V_FETCH};
        for (int i = 0; i < e.size(); i++) begin
            if (i > 0) @(negedge clk);
            nchk++;
            if (outs() !== e[i]) begin
                nerr++;
                $display("FAIL rtype_sra step %0d: got %h expected %h", i, outs(), e[i]);
            end
        end
    endtask

    task automatic test_alu_decode();
        // {op, funct3, funct7b5, expected ALUControl}
        logic [15:0] tab [5];
        tab[0] = {7'b0110011, 3'b000, 1'b1, 4'd0, 1'b0};
        tab[1] = {7'b0010011, 3'b000, 1'b1, 4'd0, 1'b0};
        tab[2] = {7'b0010011, 3'b101, 1'b1, 4'd9, 1'b0};
        tab[3] = {7'b0010011, 3'b010, 1'b0, 4'd5, 1'b0};
        tab[4] = {7'b0110011, 3'b110, 1'b0, 4'd3, 1'b0};
        // R-type funct3=000 with funct7b5 is sub
        tab[0][4:1] = 4'd1;
        for (int t = 0; t < 5; t++) begin
            logic [6:0] op;
            logic       isr;
            vec_t       ex;
            op  = tab[t][15:9];
            isr = (op == 7'b0110011);
            set_in(op, tab[t][8:6], tab[t][5]);
            ex = isr ? mk(3'd0, 2'd2, 2'd0, 2'd0, 1'b0, tab[t][4:1], 1'b0, 1'b0, 1'b0, 1'b0, 1'b0)
                     : mk(3'd0, 2'd2, 2'd1, 2'd0, 1'b0, tab[t][4:1], 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
            @(negedge clk);
            @(negedge clk);
            nchk++;
            if (outs() !== ex) begin
                nerr++;
                $display("FAIL alu_decode entry %0d: got %h expected %h", t, outs(), ex);
            end
            @(negedge clk);
            @(negedge clk);
        end
    endtask

    task automatic test_branch();
        // {funct3, Zero, Neg, Ovf, Carry, expected PCWrite}
        logic [7:0] tab [6];
        tab[0] = {3'b000, 4'b1000, 1'b1};
        tab[1] = {3'b000, 4'b0000, 1'b0};
        tab[2] = {3'b110, 4'b0000, 1'b1};
        tab[3] = {3'b111, 4'b0000, 1'b0};
        tab[4] = {3'b100, 4'b0100, 1'b1};
        tab[5] = {3'b101, 4'b0110, 1'b1};
        for (int t = 0; t < 6; t++) begin
            vec_t e[$];
            set_in(7'b1100011, tab[t][7:5], 1'b0);
            {bus.Zero, bus.Neg, bus.Ovf, bus.Carry} = tab[t][4:1];
            e = {V_FETCH, V_DEC_B,
                 mk(3'd0, 2'd2, 2'd0, 2'd0, 1'b0, 4'd1, 1'b0, tab[t][0], 1'b0, 1'b0, 1'b0),
                 V_FETCH};
            for (int i = 0; i < e.size(); i++) begin
                if (i > 0) @(negedge clk);
                nchk++;
                if (outs() !== e[i]) begin
                    nerr++;
                    $display("FAIL branch entry %0d step %0d: got %h expected %h", t, i, outs(), e[i]);
                end
            end
        end
        {bus.Zero, bus.Neg, bus.Ovf, bus.Carry} = 4'b0;
    endtask

    task automatic test_jumps();
        vec_t e[$];
        set_in(7'b1100111, 3'b000, 1'b0);
        e = {V_FETCH, V_DEC_J,
             mk(3'd0, 2'd2, 2'd1, 2'd2, 1'b0, 4'd0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0),
             mk(3'd0, 2'd1, 2'd2, 2'd2, 1'b0, 4'd0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0)};
        for (int i = 0; i < e.size(); i++) begin
            if (i > 0) @(negedge clk);
            nchk++;
            if (outs() !== e[i]) begin
                nerr++;
                $display("FAIL jalr step %0d: got %h expected %h", i, outs(), e[i]);
            end
        end
        @(negedge clk);
        set_in(7'b1101111, 3'b000, 1'b0);
        e = {V_FETCH, V_DEC_J,
             mk(3'd0, 2'd1, 2'd2, 2'd0, 1'b0, 4'd0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0),
             V_ALUWB, V_FETCH};
        for (int i = 0; i < e.size(); i++) begin
            if (i > 0) @(negedge clk);
            nchk++;
            if (outs() !== e[i]) begin
                nerr++;
                $display("FAIL jal step %0d: got %h expected %h", i, outs(), e[i]);
            end
        end
    endtask

    task automatic test_upper();
        vec_t e[$];
        set_in(7'b0110111, 3'b000, 1'b0);
        e = {V_FETCH, V_DEC_J,
             mk(3'd4, 2'd3, 2'd1, 2'd0, 1'b0, 4'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0),
             V_ALUWB};
        for (int i = 0; i < e.size(); i++) begin
            if (i > 0) @(negedge clk);
            nchk++;
            if (outs() !== e[i]) begin
                nerr++;
                $display("FAIL lui step %0d: got %h expected %h", i, outs(), e[i]);
            end
        end
        @(negedge clk);
        set_in(7'b0010111, 3'b000, 1'b0);
        e = {V_FETCH, V_DEC_J,
             mk(3'd4, 2'd1, 2'd1, 2'd0, 1'b0, 4'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0),
             V_ALUWB, V_FETCH};
        for (int i = 0; i < e.size(); i++) begin
            if (i > 0) @(negedge clk);
            nchk++;
            if (outs() !== e[i]) begin
                nerr++;
                $display("FAIL auipc step %0d: got %h expected %h", i, outs(), e[i]);
            end
        end
    endtask

    task automatic test_mem();
        vec_t e[$];
        set_in(7'b0100011, 3'b010, 1'b0);
        e = {V_FETCH, V_DEC_J,
             mk(3'd1, 2'd2, 2'd1, 2'd0, 1'b0, 4'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0),
             mk(3'd0, 2'd0, 2'd0, 2'd0, 1'b1, 4'd0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0),
             V_FETCH};
        for (int i = 0; i < e.size(); i++) begin
            if (i > 0) @(negedge clk);
            nchk++;
            if (outs() !== e[i]) begin
                nerr++;
                $display("FAIL sw step %0d: got %h expected %h", i, outs(), e[i]);
            end
        end
        set_in(7'b0000011, 3'b010, 1'b0);
        e = {V_FETCH, V_DEC_J,
             mk(3'd0, 2'd2, 2'd1, 2'd0, 1'b0, 4'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0),
             mk(3'd0, 2'd0, 2'd0, 2'd0, 1'b1, 4'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0),
             mk(3'd0, 2'd0, 2'd0, 2'd1, 1'b0, 4'd0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0),
             V_FETCH};
        for (int i = 0; i < e.size(); i++) begin
            if (i > 0) @(negedge clk);
            nchk++;
            if (outs() !== e[i]) begin
                nerr++;
                $display("FAIL lw step %0d: got %h expected %h", i, outs(), e[i]);
            end
        end
    endtask

    task automatic test_reset_midinstr();
        set_in(7'b0000011, 3'b010, 1'b0);
        @(negedge clk);
        @(negedge clk);
        reset = 1'b1;
        #1;
        nchk++;
        if (outs() !== V_FETCH) begin
            nerr++;
            $display("FAIL reset_midinstr: got %h expected %h", outs(), V_FETCH);
        end
        @(negedge clk);
        reset = 1'b0;
    endtask

    task automatic test_trap();
        vec_t e[$];
        set_in(7'b0000000, 3'b000, 1'b0);
        e = {V_FETCH, V_DEC_J};
        for (int i = 0; i < 10; i++) e.push_back(V_TRAP);
        for (int i = 0; i < e.size(); i++) begin
            if (i > 0) @(negedge clk);
            nchk++;
            if (outs() !== e[i]) begin
                nerr++;
                $display("FAIL trap step %0d: got %h expected %h", i, outs(), e[i]);
            end
        end
        #2 reset = 1'b1;
        #1;
        nchk++;
        if (outs() !== V_FETCH) begin
            nerr++;
            $display("FAIL trap_reset: got %h expected %h", outs(), V_FETCH);
        end
        @(negedge clk);
        reset = 1'b0;
        // Reserved branch funct3 also traps
        set_in(7'b1100011, 3'b011, 1'b0);
        e = {V_FETCH, V_DEC_B, V_TRAP, V_TRAP};
        for (int i = 0; i < e.size(); i++) begin
            if (i > 0) @(negedge clk);
            nchk++;
            if (outs() !== e[i]) begin
                nerr++;
                $display("FAIL branch_trap step %0d: got %h expected %h", i, outs(), e[i]);
            end
        end
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
    endtask

`ifdef MCCTRL_MEMWAIT_EN
    task automatic test_memwait();
        vec_t e[$];
        vec_t rd;
        rd = mk(3'd0, 2'd0, 2'd0, 2'd0, 1'b1, 4'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        set_in(7'b0000011, 3'b010, 1'b0);
        bus.MemReady = 1'b1;
        e = {V_FETCH, V_DEC_J,
             mk(3'd0, 2'd2, 2'd1, 2'd0, 1'b0, 4'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0)};
        for (int i = 0; i < e.size(); i++) begin
            if (i > 0) @(negedge clk);
            nchk++;
            if (outs() !== e[i]) begin
                nerr++;
                $display("FAIL memwait_lw step %0d: got %h expected %h", i, outs(), e[i]);
            end
        end
        bus.MemReady = 1'b0;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            if (i == 3) bus.MemReady = 1'b1;
            nchk++;
            if (outs() !== rd) begin
                nerr++;
                $display("FAIL memwait_hold cycle %0d: got %h expected %h", i, outs(), rd);
            end
        end
        @(negedge clk);
        nchk++;
        if (outs() !== mk(3'd0, 2'd0, 2'd0, 2'd1, 1'b0, 4'd0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0)) begin
            nerr++;
            $display("FAIL memwait_wb: got %h", outs());
        end
        @(negedge clk);
    endtask
`endif

    initial begin
        nchk    = 0;
        nerr    = 0;
        V_FETCH = mk(3'd0, 2'd0, 2'd2, 2'd2, 1'b0, 4'd0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
        V_DEC_J = mk(3'd3, 2'd1, 2'd1, 2'd0, 1'b0, 4'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        V_DEC_B = mk(3'd2, 2'd1, 2'd1, 2'd0, 1'b0, 4'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        V_ALUWB = mk(3'd0, 2'd0, 2'd0, 2'd0, 1'b0, 4'd0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
        V_TRAP  = mk(3'd0, 2'd0, 2'd0, 2'd0, 1'b0, 4'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
        test_reset();
        test_rtype();
        test_alu_decode();
        test_branch();
        test_jumps();
        test_upper();
        test_mem();
        test_reset_midinstr();
        test_trap();
`ifdef MCCTRL_MEMWAIT_EN
        test_memwait();
`endif
        $display("Simulation finished: %0d checks, %0d errors", nchk, nerr);
        $finish;
    end

    // Hard stop in case a sequence stalls
    initial begin
        #200000;
        $display("FAIL timeout: simulation did not complete");
        $fatal(1, "timeout");
    end

endmodule

// File: doc/mcctrl_rv32i.md
# mcctrl_rv32i

Parametrised multicycle RV32I control unit; successor to the single-width `controller`. Sits between the instruction register / ALU flags and the shared-memory multicycle datapath. It adds:
- lui, auipc and jalr;
- all six branch conditions;
- full shift/compare ALU decode;
- a latched illegal-opcode trap;
- an optional variable-latency memory handshake.

## Interface
Parameters:
- ALUCTRL_W, 4, ALUControl width; legal values ≥4; codes are zero-extended into the upper bits.

Ports:
- clk  in  1  rising-edge clock
- reset  in  1  asynchronous, active-high
- op  in  7  instruction opcode
- funct3  in  3  instruction funct3
- funct7b5  in  1  instruction bit 30
- Zero, Neg, Ovf, Carry  in  1 each  ALU flags of the current ALU result; Carry=1 means no borrow on sub
- MemReady  in  1  memory completes the access this cycle (used only with MCCTRL_MEMWAIT_EN)
- ImmSrc  out  3  000 I, 001 S, 010 B, 011 J, 100 U
- ALUSrcA  out  2  00 PC, 01 OldPC, 10 A (rs1), 11 zero
- ALUSrcB  out  2  00 WriteData (rs2), 01 ImmExt, 10 constant 4
- ResultSrc  out  2  00 ALUOut, 01 Data, 10 ALUResult
- AdrSrc  out  1  0 PC, 1 Result
- ALUControl  out  ALUCTRL_W  operation code: 0 add, 1 sub, 2 and, 3 or, 4 xor, 5 slt, 6 sltu, 7 sll, 8 srl, 9 sra
- IRWrite, PCWrite, RegWrite, MemWrite  out  1 each  datapath enables
- Fault  out  1  illegal instruction trapped

## Operation
- All outputs are Moore outputs decoded from the state register, with two exceptions:
  - PCWrite in BRANCH is combinational on the flags.
  - Enables gated by MemReady (see Configuration).
- Outputs not listed for a state are 0, including ImmSrc = 000.
- Reset state is FETCH.

State actions and transitions:
- FETCH: AdrSrc 0, IRWrite 1, ALUSrcA 00, ALUSrcB 10, add, ResultSrc 10, PCWrite 1. Next: DECODE.
- DECODE: ALUSrcA 01, ALUSrcB 01, add, ImmSrc B (for branch op) or J (otherwise). Next state by opcode:
  - lw, sw → MEMADR
  - R-type → EXECR
  - I-ALU → EXECI
  - jal → JAL
  - jalr → JALR
  - branch → BRANCH; branch funct3 010/011 → TRAP
  - lui → LUI
  - auipc → AUIPC
  - any other opcode → TRAP
- MEMADR: ALUSrcA 10, ALUSrcB 01, add, ImmSrc I (lw) / S (sw). Next: MEMREAD (lw) or MEMWRITE (sw).
- MEMREAD: ResultSrc 00, AdrSrc 1. Next: MEMWB.
- MEMWB: ResultSrc 01, RegWrite. Next: FETCH.
- MEMWRITE: ResultSrc 00, AdrSrc 1, MemWrite. Next: FETCH.
- EXECR: ALUSrcA 10, ALUSrcB 00, ALU decode. Next: ALUWB.
- EXECI: ALUSrcA 10, ALUSrcB 01, ImmSrc I, ALU decode. Next: ALUWB.
- ALUWB: ResultSrc 00, RegWrite. Next: FETCH.
- JAL: ALUSrcA 01, ALUSrcB 10, add, ResultSrc 00, PCWrite. Next: ALUWB.
- JALR: ALUSrcA 10, ALUSrcB 01, ImmSrc I, add, ResultSrc 10, PCWrite. Next: JALRWB. The datapath clears the LSB of the target.
- JALRWB: ALUSrcA 01, ALUSrcB 10, add, ResultSrc 10, RegWrite. Next: FETCH.
- LUI: ALUSrcA 11, ALUSrcB 01, ImmSrc U, add. Next: ALUWB.
- AUIPC: ALUSrcA 01, ALUSrcB 01, ImmSrc U, add. Next: ALUWB.
- BRANCH: ALUSrcA 10, ALUSrcB 00, sub, ResultSrc 00. PCWrite = taken. Next: FETCH. Taken condition by funct3:
  - 000 Zero
  - 001 ~Zero
  - 100 Neg^Ovf
  - 101 ~(Neg^Ovf)
  - 110 ~Carry
  - 111 Carry
- TRAP: Fault=1, all enables 0. Stays in TRAP until reset.

ALU decode, by funct3:
- 000: add; sub only when op[5] & funct7b5 (R-type).
- 001 sll, 010 slt, 011 sltu, 100 xor, 110 or, 111 and.
- 101: srl, or sra when funct7b5 (both R and I forms).

## Timing
- Instruction latency in cycles (no wait states):
  - branch 3
  - R-type, I-ALU, lui, auipc 4
  - jal 4
  - jalr 4
  - sw 4
  - lw 5
- Reset mid-instruction: state returns to FETCH immediately (asynchronous). Outputs take FETCH values the same cycle; Fault clears.
- Output values while reset is asserted: IRWrite=1, PCWrite=1, ALUSrcB=10, ResultSrc=10, all other outputs 0. The datapath must hold its own registers during reset.

## Configuration
- MCCTRL_MEMWAIT_EN defined:
  - FETCH, MEMREAD and MEMWRITE hold until MemReady=1.
  - IRWrite and PCWrite in FETCH are ANDed with MemReady.
  - MemWrite stays asserted while waiting; memory must count the held write as one access.
  - The state advances on the cycle MemReady=1.
- Undefined: MemReady is ignored (treated as 1); timing is exactly as above.

## Structure
- Package mcctrl_pkg holds:
  - state enum
  - opcode localparams
  - ALUControl codes
  - ImmSrc / ALUSrcA / ALUSrcB / ResultSrc codes
- Sub-module mcctrl_aludec: combinational; inputs op[5], funct3, funct7b5, mode (add/sub/decode); output ALUControl.
- Branch-condition evaluation stays in the top module.

## Test plan
- Reset then op=0110011, funct3=101, funct7b5=1 → FETCH, DECODE, EXECR (ALUControl=9), ALUWB (RegWrite=1), FETCH.
- beq op=1100011 funct3=000 with Zero=1 → BRANCH PCWrite=1; same with Zero=0 → PCWrite=0. bltu (110) with Carry=0 → PCWrite=1.
- jalr op=1100111 → JALR PCWrite=1 ResultSrc=10; then JALRWB RegWrite=1 ALUSrcA=01 ALUSrcB=10; 4 cycles total.
- lui op=0110111 → LUI ALUSrcA=11 ImmSrc=100; auipc op=0010111 → ALUSrcA=01 ImmSrc=100.
- op=0000000 → TRAP: Fault=1 for 10 cycles with all enables 0; reset pulse → FETCH, Fault=0.
- With MCCTRL_MEMWAIT_EN, lw with MemReady low for 3 cycles in MEMREAD → AdrSrc=1 held 4 cycles, then MEMWB RegWrite=1.
